// File: rtl/temp_ctrl_pkg.sv
// Shared types and constants for the temperature sample controller.
// Holds the state enum and the raw-to-tenths conversion constants.
package temp_ctrl_pkg;

  localparam int RAW_W  = 13;
  localparam int CALC_W = 17;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CALC,
    WRITE,
    ERR
  } state_e;

  // Raw LSB is 1/16 degC; x5>>>3 gives tenths of degC, x9>>>3 gives tenths of a F-degree.
  localparam logic signed [CALC_W-1:0] C_SCALE         = 17'sd5;
  localparam logic signed [CALC_W-1:0] F_SCALE         = 17'sd9;
  localparam logic signed [CALC_W-1:0] F_OFFSET_TENTHS = 17'sd320;
  localparam int                       SCALE_SHIFT     = 3;

endpackage

// File: rtl/temp_scale.sv
// Combinational conversion of a raw 1/16 degC reading into tenths of a degree,
// returned as sign plus 13-bit magnitude.
module temp_scale
  import temp_ctrl_pkg::*;
(
  input  logic [RAW_W-1:0] raw_i,
  input  logic             select_cf_i,
  output logic [RAW_W-1:0] mag_o,
  output logic             neg_o
);

  logic signed [CALC_W-1:0] raw_ext;
  logic signed [CALC_W-1:0] v;

  always_comb begin
    raw_ext = {{(CALC_W-RAW_W){raw_i[RAW_W-1]}}, raw_i};
    // Arithmetic shift floors toward minus infinity, so -1/16 degC reads as -0.1.
    if (select_cf_i) v = ((raw_ext * F_SCALE) >>> SCALE_SHIFT) + F_OFFSET_TENTHS;
    else             v = (raw_ext * C_SCALE) >>> SCALE_SHIFT;
  end

  assign neg_o = v[CALC_W-1];
  assign mag_o = RAW_W'(neg_o ? -v : v);

endmodule

// File: rtl/temp_sample_ctrl.sv
// Periodic sensor sampler: requests a reading every SAMPLE_CYCLES, converts it to
// tenths of C/F, recomputes on a C/F change. Define TEMP_SAMPLE_CTRL_TIMEOUT_EN for ack timeout.
module temp_sample_ctrl
  import temp_ctrl_pkg::*;
#(
  parameter int unsigned SAMPLE_CYCLES  = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             select_cf,
  input  logic             sens_ack,
  input  logic [RAW_W-1:0] sens_data,
  output logic             sens_req,
  output logic [RAW_W-1:0] temp,
  output logic             neg,
  output logic             temp_valid,
  output logic             err
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_CYCLES);

  if (SAMPLE_CYCLES < 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("temp_sample_ctrl: SAMPLE_CYCLES must be >= 8 and TIMEOUT_CYCLES >= 1");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire;
  logic             pending_q, pending_d;
  logic [RAW_W-1:0] raw_q, raw_d;
  logic             raw_valid_q, raw_valid_d;
  logic             cf_used_q, cf_used_d;
  logic [RAW_W-1:0] mag_q, mag_d;
  logic             sneg_q, sneg_d;
  logic [RAW_W-1:0] temp_q, temp_d;
  logic             neg_q, neg_d;
  logic             temp_valid_q, temp_valid_d;
  logic             sens_req_q, sens_req_d;
  logic [RAW_W-1:0] scale_mag;
  logic             scale_neg;

  temp_scale u_scale (
    .raw_i       (raw_q),
    .select_cf_i (select_cf),
    .mag_o       (scale_mag),
    .neg_o       (scale_neg)
  );

  assign expire = (cnt_q == '0);
  assign cnt_d  = expire ? CNT_W'(SAMPLE_CYCLES - 1) : cnt_q - 1'b1;

`ifdef TEMP_SAMPLE_CTRL_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_q, to_d;
  logic            err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first, so no branch can infer a latch.
    state_d      = state_q;
    pending_d    = pending_q | expire;
    raw_d        = raw_q;
    raw_valid_d  = raw_valid_q;
    cf_used_d    = cf_used_q;
    mag_d        = mag_q;
    sneg_d       = sneg_q;
    temp_d       = temp_q;
    neg_d        = neg_q;
    temp_valid_d = 1'b0;
`ifdef TEMP_SAMPLE_CTRL_TIMEOUT_EN
    err_d        = err_q;
    to_d         = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pending_q || expire) begin
          pending_d = 1'b0;
          state_d   = REQ;
        end else if (raw_valid_q && (select_cf != cf_used_q)) begin
          state_d = CALC;
        end
      end
      REQ: begin
        if (sens_ack) begin
          raw_d       = sens_data;
          raw_valid_d = 1'b1;
          state_d     = CALC;
        end
`ifdef TEMP_SAMPLE_CTRL_TIMEOUT_EN
        else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ERR;
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
      end
      CALC: begin
        cf_used_d = select_cf;
        mag_d     = scale_mag;
        sneg_d    = scale_neg;
        state_d   = WRITE;
      end
      WRITE: begin
        temp_d       = mag_q;
        neg_d        = sneg_q;
        temp_valid_d = 1'b1;
`ifdef TEMP_SAMPLE_CTRL_TIMEOUT_EN
        err_d        = 1'b0;
`endif
        state_d      = IDLE;
      end
      ERR: begin
`ifdef TEMP_SAMPLE_CTRL_TIMEOUT_EN
        err_d   = 1'b1;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request is registered off the next state so it rises on REQ entry and falls right after the ack.
  assign sens_req_d = (state_d == REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= CNT_W'(SAMPLE_CYCLES - 1);
      pending_q    <= 1'b0;
      raw_q        <= '0;
      raw_valid_q  <= 1'b0;
      cf_used_q    <= 1'b0;
      mag_q        <= '0;
      sneg_q       <= 1'b0;
      temp_q       <= '0;
      neg_q        <= 1'b0;
      temp_valid_q <= 1'b0;
      sens_req_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      raw_q        <= raw_d;
      raw_valid_q  <= raw_valid_d;
      cf_used_q    <= cf_used_d;
      mag_q        <= mag_d;
      sneg_q       <= sneg_d;
      temp_q       <= temp_d;
      neg_q        <= neg_d;
      temp_valid_q <= temp_valid_d;
      sens_req_q   <= sens_req_d;
    end
  end

  assign sens_req   = sens_req_q;
  assign temp       = temp_q;
  assign neg        = neg_q;
  assign temp_valid = temp_valid_q;

endmodule

// File: tb/tb_temp_sample_ctrl.sv
// Directed bench for temp_sample_ctrl with SAMPLE_CYCLES=16, TIMEOUT_CYCLES=8.
// Timeout steps are compiled in when TEMP_SAMPLE_CTRL_TIMEOUT_EN is defined.
module tb_temp_sample_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        select_cf = 1'b0;
  logic        sens_ack = 1'b0;
  logic [12:0] sens_data = '0;
  logic        sens_req;
  logic [12:0] temp;
  logic        neg;
  logic        temp_valid;
  logic        err;

  int checks = 0;
  int errors = 0;

  temp_sample_ctrl #(
    .SAMPLE_CYCLES  (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .select_cf  (select_cf),
    .sens_ack   (sens_ack),
    .sens_data  (sens_data),
    .sens_req   (sens_req),
    .temp       (temp),
    .neg        (neg),
    .temp_valid (temp_valid),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (sens_req !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check({tag, "_req_seen"}, 32'(sens_req), 1);
  endtask

  // Acks the pending request with data and checks the 2-cycle result latency.
  task automatic do_read(input string tag, input logic [12:0] data,
                         input logic [12:0] exp_t, input logic exp_n);
    wait_req(tag);
    sens_ack  = 1'b1;
    sens_data = data;
    tick();
    sens_ack  = 1'b0;
    sens_data = '0;
    check({tag, "_req_drop"}, 32'(sens_req), 0);
    check({tag, "_valid_e0"}, 32'(temp_valid), 0);
    tick();
    check({tag, "_valid_e1"}, 32'(temp_valid), 0);
    tick();
    check({tag, "_valid"}, 32'(temp_valid), 1);
    check({tag, "_temp"}, 32'(temp), 32'(exp_t));
    check({tag, "_neg"}, 32'(neg), 32'(exp_n));
    tick();
    check({tag, "_valid_end"}, 32'(temp_valid), 0);
  endtask

  // Changes select_cf in IDLE and checks the recompute without a sensor request.
  task automatic recompute(input string tag, input logic cf,
                           input logic [12:0] exp_t, input logic exp_n);
    select_cf = cf;
    tick();
    check({tag, "_no_req0"}, 32'(sens_req), 0);
    tick();
    check({tag, "_valid_e1"}, 32'(temp_valid), 0);
    tick();
    check({tag, "_valid"}, 32'(temp_valid), 1);
    check({tag, "_temp"}, 32'(temp), 32'(exp_t));
    check({tag, "_neg"}, 32'(neg), 32'(exp_n));
    check({tag, "_no_req2"}, 32'(sens_req), 0);
    tick();
    check({tag, "_valid_end"}, 32'(temp_valid), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req"}, 32'(sens_req), 0);
    check({tag, "_temp"}, 32'(temp), 0);
    check({tag, "_neg"}, 32'(neg), 0);
    check({tag, "_valid"}, 32'(temp_valid), 0);
    check({tag, "_err"}, 32'(err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    logic saw_valid;

    // Reset state
    #1 rst_n = 1'b0;
    #2 check_outputs_zero("rst");
    tick();
    tick();
    rst_n = 1'b1;

    // C/F toggle before any reading must not trigger a recompute; first request at 16 cycles
    saw_valid = 1'b0;
    select_cf = 1'b1;
    n = 0;
    repeat (3) begin
      tick();
      n++;
      saw_valid |= temp_valid;
    end
    select_cf = 1'b0;
    while (sens_req !== 1'b1 && n < 40) begin
      tick();
      n++;
      saw_valid |= temp_valid;
    end
    check("first_req_cycles", n, 16);
    check("no_recompute_without_raw", 32'(saw_valid), 0);

    // Conversions and recomputes
    do_read("c_400", 13'd400, 13'd250, 1'b0);
    recompute("rc_f_400", 1'b1, 13'd770, 1'b0);
    do_read("f_400", 13'd400, 13'd770, 1'b0);
    recompute("rc_c_400", 1'b0, 13'd250, 1'b0);
    do_read("c_m160", 13'(-160), 13'd100, 1'b1);
    recompute("rc_f_m160", 1'b1, 13'd140, 1'b0);
    do_read("f_m880", 13'(-880), 13'd670, 1'b1);
    recompute("rc_c_m880", 1'b0, 13'd550, 1'b1);
    do_read("c_m1", 13'(-1), 13'd1, 1'b1);
    recompute("rc_f_m1", 1'b1, 13'd318, 1'b0);
    do_read("f_2400", 13'd2400, 13'd3020, 1'b0);
    recompute("rc_c_2400", 1'b0, 13'd1500, 1'b0);

`ifdef TEMP_SAMPLE_CTRL_TIMEOUT_EN
    // Unanswered request times out after 8 cycles
    wait_req("to");
    n = 0;
    while (sens_req === 1'b1 && n < 32) begin
      tick();
      n++;
    end
    check("to_req_cycles", n, 8);
    tick();
    check("to_err_set", 32'(err), 1);
    check("to_temp_kept", 32'(temp), 1500);
    check("to_neg_kept", 32'(neg), 0);
    check("to_no_valid", 32'(temp_valid), 0);
    do_read("to_recover", 13'd400, 13'd250, 1'b0);
    check("to_err_clear", 32'(err), 0);
`else
    // Ack held off for 38 cycles: two expiries collapse into one pending request
    wait_req("dly");
    repeat (38) tick();
    check("dly_req_held", 32'(sens_req), 1);
    check("dly_err_zero", 32'(err), 0);
    sens_ack  = 1'b1;
    sens_data = 13'd800;
    tick();
    sens_ack  = 1'b0;
    tick();
    tick();
    check("dly_valid", 32'(temp_valid), 1);
    check("dly_temp", 32'(temp), 500);
    tick();
    check("dly_pending_req", 32'(sens_req), 1);
    do_read("dly_pend", 13'(-880), 13'd550, 1'b1);
    check("dly_no_extra_req0", 32'(sens_req), 0);
    tick();
    check("dly_no_extra_req1", 32'(sens_req), 0);
    tick();
    check("dly_next_period_req", 32'(sens_req), 1);
`endif

    // Asynchronous reset in the middle of a request
    wait_req("mid");
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("mid_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    while (sens_req !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("post_rst_req_cycles", n, 16);
    do_read("post_rst", 13'd400, 13'd250, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
